letc_core_redirect_sequencer: RTL and testbench
===============================================

// Module: letc_core_redirect_sequencer
// PURPOSE
//  Sequences control-flow redirects (taken branches, jumps, traps) for the LETC core pipeline.
//  Arbitrates same-cycle redirect requests from pipeline stages; the oldest stage wins.
//  Issues one-cycle flushes to every younger stage and holds the redirect PC until fetch accepts it.
//  Sits beside the hazard/bubble glue and drives the per-stage flush and stall vectors.
// PARAMETERS
//  NUM_STAGES  5   pipeline stages; index 0 = fetch (youngest), NUM_STAGES-1 = oldest
//  PC_W        32  redirect target width
//  CNT_W       16  perf counter width
// PORTS
//  clk                 in   1                clock, all state on rising edge
//  rst_n               in   1                asynchronous active-low reset
//  redirect_req        in   NUM_STAGES       per-stage redirect request, level, sampled each cycle
//  redirect_pc         in   NUM_STAGES*PC_W  per-stage target; stage i at [i*PC_W +: PC_W]
//  stage_ready         in   NUM_STAGES       stage i can accept/advance this cycle
//  stage_flush         out  NUM_STAGES       registered one-cycle flush per stage
//  stage_stall         out  NUM_STAGES       per-stage stall (combinational from state + stage_ready)
//  fetch_redirect_vld  out  1                redirect target valid to fetch
//  fetch_redirect_pc   out  PC_W             redirect target
//  fetch_redirect_rdy  in   1                fetch accepts target (vld & rdy = handshake)
//  busy                out  1                FSM not IDLE
//  redirect_count      out  CNT_W            completed redirect handshakes, wraps
// BEHAVIOUR
//  Reset (async assert, sync deassert use):
//  - state=IDLE; winner index W=0; latched PC=0.
//  - stage_flush=0, fetch_redirect_vld=0, fetch_redirect_pc=0, busy=0, redirect_count=0.
//  Arbitration:
//  - W = highest index i with redirect_req[i]=1 (oldest stage wins).
//  - Lower-index requests in the same cycle are discarded.
//  FSM states: IDLE, FLUSH, REDIRECT.
//  - IDLE: if any req -> latch W and redirect_pc[W], go FLUSH next cycle (latency 1).
//  - FLUSH (exactly 1 cycle):
//    - stage_flush[i]=1 for all i<W; 0 for i>=W (requester itself is not flushed).
//    - fetch_redirect_vld=1. If rdy -> count++, go IDLE; else go REDIRECT.
//  - REDIRECT: vld held at 1 with PC stable until rdy; on handshake count++, go IDLE.
//  Preemption (FLUSH or REDIRECT):
//  - A new request at index > latched W re-latches W and PC, re-enters FLUSH next cycle.
//  - The old target is dropped without a handshake and is not counted.
//  - Requests at index <= latched W are ignored; those stages are flushed or younger.
//  - Preemption has priority over a same-cycle handshake; the handshake is not counted.
//  Return to IDLE:
//  - On the handshake cycle the FSM returns to IDLE.
//  - A new request in the first IDLE cycle is accepted normally; no dead cycle beyond the FLUSH latency.
//  Stalls:
//  - stage_stall[i] = ~&stage_ready[NUM_STAGES-1:i+1] (backpressure from any older stage).
//  - stage_stall[NUM_STAGES-1] = 0 from this term.
//  - While busy, stage_stall[0]=1 additionally (fetch holds until the redirect is accepted).
//  - stage_flush has priority over stage_stall in consumers; both may be 1 in the same cycle.
//  Widths: redirect_count wraps at 2^CNT_W-1 -> 0. W is clog2(NUM_STAGES) bits.
//  Reset mid-operation: immediately returns to reset values; a pending redirect is lost.
// TESTING
//  - Single redirect:
//    - Stimulus: req[2]=1, pc=0x0000_1000 at cycle N; rdy=1.
//    - Response: N+1 flush=5'b00011, vld=1, pc=0x1000; N+2 busy=0; count=1.
//  - Simultaneous requests:
//    - Stimulus: req[1]=1 (pc 0x200) and req[3]=1 (pc 0x300) at cycle N.
//    - Response: flush=5'b00111, pc=0x300, exactly one handshake.
//  - Backpressured fetch:
//    - Stimulus: req[2], rdy=0 for 4 cycles, then rdy=1.
//    - Response: vld and pc stable for 5 cycles; flush high only in the first cycle;
//      stage_stall[0]=1 throughout; count +1.
//  - Preemption:
//    - Stimulus: in REDIRECT for W=1, req[4] (pc 0x400) arrives with rdy=1 the same cycle.
//    - Response: no count; next cycle flush=5'b01111, pc=0x400.
//    - Stimulus (ignored case): req[0] in REDIRECT.
//    - Response: no effect.
//  - Async reset:
//    - Stimulus: rst_n low mid-REDIRECT.
//    - Response: outputs 0 the same cycle, busy=0, count=0.
//  - Counter wrap:
//    - Stimulus: CNT_W=2, 5 redirects.
//    - Response: count=1.
//  - Stall vector:
//    - Stimulus: stage_ready=5'b10111, idle.
//    - Response: stage_stall=5'b00111.

Source files
------------

// File: rtl/letc_core_redirect_sequencer.sv
// ---------------------------------------------------------------------------
// letc_core_redirect_sequencer
//
// Purpose:
//   Sequences control-flow redirects (taken branches, jumps, traps) for the
//   LETC core pipeline. When several stages request a redirect in the same
//   cycle, the oldest stage (highest index) wins. The sequencer then:
//     - issues a one-cycle flush to every stage younger than the winner;
//     - holds the redirect target towards fetch until fetch accepts it.
//   It also drives the per-stage stall vector.
//
// Ports:
//   clk                 clock, all state on the rising edge
//   rst_n               asynchronous active-low reset
//   redirect_req        per-stage redirect request (level)
//   redirect_pc         per-stage target, stage i at [i*PC_W +: PC_W]
//   stage_ready         stage i can accept/advance this cycle
//   stage_flush         registered one-cycle flush per stage
//   stage_stall         per-stage stall (from state and stage_ready)
//   fetch_redirect_vld  redirect target valid to fetch
//   fetch_redirect_pc   redirect target
//   fetch_redirect_rdy  fetch accepts the target (vld & rdy = handshake)
//   busy                sequencer is not idle
//   redirect_count      completed redirect handshakes, wraps
// ---------------------------------------------------------------------------
module letc_core_redirect_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int PC_W       = 32,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_STAGES-1:0]      redirect_req,
    input  logic [NUM_STAGES*PC_W-1:0] redirect_pc,
    input  logic [NUM_STAGES-1:0]      stage_ready,
    output logic [NUM_STAGES-1:0]      stage_flush,
    output logic [NUM_STAGES-1:0]      stage_stall,
    output logic                       fetch_redirect_vld,
    output logic [PC_W-1:0]            fetch_redirect_pc,
    input  logic                       fetch_redirect_rdy,
    output logic                       busy,
    output logic [CNT_W-1:0]           redirect_count
);

    localparam int W_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    state_t                  state_reg;
    logic [W_W-1:0]          w_reg;
    logic [NUM_STAGES-1:0]   flush_reg;
    logic                    vld_reg;
    logic [PC_W-1:0]         pc_reg;
    logic                    busy_reg;
    logic [CNT_W-1:0]        count_reg;

    // Per-stage targets unpacked for indexed selection by the winner.
    logic [PC_W-1:0]         pc_arr [NUM_STAGES];
    logic [NUM_STAGES-1:0]   win_mask;
    logic [NUM_STAGES-1:0]   older_stall;
    logic [W_W-1:0]          win_idx;
    logic                    any_req;
    logic                    preempt;
    logic [PC_W-1:0]         win_pc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign pc_arr[gi]   = redirect_pc[gi*PC_W +: PC_W];
            // Flush only stages strictly younger than the winner.
            assign win_mask[gi] = (W_W'(gi) < win_idx);
        end
        for (gi = 0; gi < NUM_STAGES-1; gi++) begin : g_stall
            // Any older stage not ready backpressures this one.
            assign older_stall[gi] = ~&stage_ready[NUM_STAGES-1:gi+1];
        end
    endgenerate
    assign older_stall[NUM_STAGES-1] = 1'b0;

    // Oldest requester wins: the last set bit scanning upward.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (redirect_req[i]) begin
                win_idx = W_W'(i);
            end
        end
    end

    assign any_req = |redirect_req;
    assign win_pc  = pc_arr[win_idx];
    // Only a strictly older stage can displace an in-flight redirect;
    // anything at or below the latched winner is already being flushed.
    assign preempt = any_req && (win_idx > w_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            w_reg     <= '0;
            flush_reg <= '0;
            vld_reg   <= 1'b0;
            pc_reg    <= '0;
            busy_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            flush_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        state_reg <= ST_FLUSH;
                        w_reg     <= win_idx;
                        pc_reg    <= win_pc;
                        flush_reg <= win_mask;
                        vld_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_FLUSH, ST_REDIRECT: begin
                    // Preemption outranks a same-cycle handshake: the old
                    // target is dropped and not counted.
                    if (preempt) begin
                        state_reg <= ST_FLUSH;
                        w_reg     <= win_idx;
                        pc_reg    <= win_pc;
                        flush_reg <= win_mask;
                    end else if (fetch_redirect_rdy) begin
                        state_reg <= ST_IDLE;
                        vld_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        count_reg <= count_reg + CNT_W'(1);
                    end else begin
                        state_reg <= ST_REDIRECT;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    vld_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign stage_flush        = flush_reg;
    // Fetch also holds while a redirect is outstanding.
    assign stage_stall        = older_stall | {{(NUM_STAGES-1){1'b0}}, busy_reg};
    assign fetch_redirect_vld = vld_reg;
    assign fetch_redirect_pc  = pc_reg;
    assign busy               = busy_reg;
    assign redirect_count     = count_reg;

endmodule

// File: tb/tb_letc_core_redirect_sequencer.sv
module tb_letc_core_redirect_sequencer;

    localparam int NS    = 5;
    localparam int PCW   = 32;
    localparam int CW    = 2;   // small counter so wrap is reachable

    logic               clk;
    logic               rst_n;
    logic [NS-1:0]      redirect_req;
    logic [NS*PCW-1:0]  redirect_pc;
    logic [NS-1:0]      stage_ready;
    logic [NS-1:0]      stage_flush;
    logic [NS-1:0]      stage_stall;
    logic               fetch_redirect_vld;
    logic [PCW-1:0]     fetch_redirect_pc;
    logic               fetch_redirect_rdy;
    logic               busy;
    logic [CW-1:0]      redirect_count;

    int total = 0;
    int bad   = 0;

    letc_core_redirect_sequencer #(
        .NUM_STAGES(NS), .PC_W(PCW), .CNT_W(CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .redirect_req       (redirect_req),
        .redirect_pc        (redirect_pc),
        .stage_ready        (stage_ready),
        .stage_flush        (stage_flush),
        .stage_stall        (stage_stall),
        .fetch_redirect_vld (fetch_redirect_vld),
        .fetch_redirect_pc  (fetch_redirect_pc),
        .fetch_redirect_rdy (fetch_redirect_rdy),
        .busy               (busy),
        .redirect_count     (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A redirect is "pending" from acceptance until fetch takes it; it is
    // "fresh" in the single cycle after it was accepted (flush cycle).
    bit        m_pending;
    bit        m_fresh;
    int        m_w;
    logic [31:0] m_pc;
    int        m_count;

    function automatic int oldest_req(input logic [NS-1:0] r);
        int hi = -1;
        for (int i = 0; i < NS; i++) if (r[i]) hi = i;
        return hi;
    endfunction

    always @(posedge clk) begin
        int hi;
        logic [NS-1:0] exp_stall;
        logic [NS-1:0] exp_flush;
        if (!rst_n) begin
            m_pending = 0; m_fresh = 0; m_w = 0; m_pc = '0; m_count = 0;
        end else begin
            hi = oldest_req(redirect_req);
            if (!m_pending || hi > m_w) begin
                if (hi >= 0) begin
                    m_pending = 1; m_fresh = 1; m_w = hi;
                    m_pc = redirect_pc[hi*PCW +: PCW];
                end else begin
                    m_fresh = 0;
                end
            end else if (fetch_redirect_rdy) begin
                m_pending = 0; m_fresh = 0;
                m_count = (m_count + 1) % (1 << CW);
            end else begin
                m_fresh = 0;
            end
        end
        #1;
        exp_flush = m_fresh ? NS'((1 << m_w) - 1) : '0;
        for (int i = 0; i < NS; i++) begin
            exp_stall[i] = 1'b0;
            for (int j = i + 1; j < NS; j++) if (!stage_ready[j]) exp_stall[i] = 1'b1;
        end
        if (m_pending) exp_stall[0] = 1'b1;
        chk("m_flush", 64'(stage_flush), 64'(exp_flush));
        chk("m_vld",   64'(fetch_redirect_vld), 64'(m_pending));
        chk("m_busy",  64'(busy), 64'(m_pending));
        chk("m_count", 64'(redirect_count), 64'(m_count));
        chk("m_stall", 64'(stage_stall), 64'(exp_stall));
        if (m_pending || !rst_n) chk("m_pc", 64'(fetch_redirect_pc), 64'(m_pc));
    end

    // ---------------- stimulus ----------------
    task automatic put_req(input int idx, input logic [31:0] pc);
        redirect_req[idx] = 1'b1;
        redirect_pc[idx*PCW +: PCW] = pc;
    endtask

    task automatic clr_req();
        redirect_req = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_req = '0;
        redirect_pc = '0;
        stage_ready = '1;
        fetch_redirect_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_vld",   64'(fetch_redirect_vld), 64'h0);
        chk("rst_busy",  64'(busy), 64'h0);
        chk("rst_count", 64'(redirect_count), 64'h0);
        chk("rst_flush", 64'(stage_flush), 64'h0);
        rst_n = 1'b1;

        // Single redirect from stage 2.
        @(negedge clk);
        put_req(2, 32'h0000_1000);
        @(negedge clk);
        clr_req();
        chk("single_flush", 64'(stage_flush), 64'h03);
        chk("single_pc", 64'(fetch_redirect_pc), 64'h1000);
        chk("single_vld", 64'(fetch_redirect_vld), 64'h1);
        @(negedge clk);
        chk("single_busy", 64'(busy), 64'h0);
        chk("single_count", 64'(redirect_count), 64'h1);
        $display("txn single redirect count=%0d", redirect_count);

        // Simultaneous requests: stage 3 beats stage 1.
        put_req(1, 32'h200);
        put_req(3, 32'h300);
        @(negedge clk);
        clr_req();
        chk("simul_flush", 64'(stage_flush), 64'h07);
        chk("simul_pc", 64'(fetch_redirect_pc), 64'h300);
        @(negedge clk);
        chk("simul_count", 64'(redirect_count), 64'h2);
        $display("txn simultaneous redirect count=%0d", redirect_count);

        // Backpressured fetch: 4 cycles not ready, accepted in the 5th.
        fetch_redirect_rdy = 1'b0;
        put_req(2, 32'h2220);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            clr_req();
            chk("bp_vld", 64'(fetch_redirect_vld), 64'h1);
            chk("bp_pc", 64'(fetch_redirect_pc), 64'h2220);
            chk("bp_flush", 64'(stage_flush), (k == 1) ? 64'h03 : 64'h0);
            chk("bp_stall0", 64'(stage_stall[0]), 64'h1);
            if (k == 5) fetch_redirect_rdy = 1'b1;
        end
        @(negedge clk);
        chk("bp_vld_done", 64'(fetch_redirect_vld), 64'h0);
        chk("bp_count", 64'(redirect_count), 64'h3);
        $display("txn backpressured redirect count=%0d", redirect_count);

        // Preemption: W=1 in REDIRECT, then ignored req[0], then req[4] with rdy.
        fetch_redirect_rdy = 1'b0;
        put_req(1, 32'h100);
        @(negedge clk);
        clr_req();
        chk("pre_flush1", 64'(stage_flush), 64'h01);
        @(negedge clk);
        put_req(0, 32'h999);
        @(negedge clk);
        clr_req();
        chk("ign_pc", 64'(fetch_redirect_pc), 64'h100);
        chk("ign_flush", 64'(stage_flush), 64'h0);
        put_req(4, 32'h400);
        fetch_redirect_rdy = 1'b1;
        @(negedge clk);
        clr_req();
        chk("pre_flush4", 64'(stage_flush), 64'h0F);
        chk("pre_pc", 64'(fetch_redirect_pc), 64'h400);
        chk("pre_nocount", 64'(redirect_count), 64'h3);
        @(negedge clk);
        chk("wrap_count0", 64'(redirect_count), 64'h0);
        $display("txn preempted redirect count=%0d", redirect_count);

        // Fifth redirect: counter reaches 1 after wrapping.
        put_req(0, 32'h50);
        @(negedge clk);
        clr_req();
        chk("w0_flush", 64'(stage_flush), 64'h0);
        @(negedge clk);
        chk("wrap_count1", 64'(redirect_count), 64'h1);
        $display("txn fifth redirect count=%0d", redirect_count);

        // Held request: re-accepted in the first IDLE cycle after each handshake.
        put_req(3, 32'h30);
        repeat (4) @(negedge clk);
        clr_req();
        @(negedge clk);
        $display("txn back-to-back redirects count=%0d", redirect_count);

        // Stall vector while idle.
        repeat (2) @(negedge clk);
        stage_ready = 5'b10111;
        #1;
        chk("stall_vec", 64'(stage_stall), 64'h07);
        @(negedge clk);
        stage_ready = '1;
        $display("txn stall vector");

        // Async reset mid-REDIRECT.
        fetch_redirect_rdy = 1'b0;
        put_req(2, 32'hABC);
        @(negedge clk);
        clr_req();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(fetch_redirect_vld), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_count", 64'(redirect_count), 64'h0);
        chk("arst_pc", 64'(fetch_redirect_pc), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_redirect_rdy = 1'b1;
        repeat (2) @(negedge clk);
        $display("txn async reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
